cgra_cfg_initiator: RTL and testbench
=====================================

Name: cgra_cfg_initiator

Overview:
- Initiator side of the CGRA column configuration register-file bus.
- Accepts single read/write requests from the global-buffer config path over a valid/ready interface.
- Drives the shared cfg_wr_en/cfg_rd_en/cfg_addr/cfg_wr_data bus to all columns, then OR-collects the per-column read returns.
- Returns one response per request, with a timeout error if no column answers.

Parameters:
- CGRA_CFG_ADDR_WIDTH, 32, config address width; addr[4:0] is the column id, addr[15:8] is the register index.
- CGRA_CFG_DATA_WIDTH, 32, config data width.
- NUM_COLUMNS, 32, number of columns on the bus (ids 0..NUM_COLUMNS-1).
- RD_TIMEOUT, 15, RD_WAIT cycles without a valid before an error response.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  CGRA_CFG_ADDR_WIDTH  config address
- req_wr_data  in  CGRA_CFG_DATA_WIDTH  write data
- resp_valid  out  1  response valid; held until resp_ready
- resp_ready  in  1  response consumed
- resp_data  out  CGRA_CFG_DATA_WIDTH  read data (0 for writes and errors)
- resp_err  out  1  read timeout or multiple responders
- cfg_wr_en  out  1  bus write strobe
- cfg_rd_en  out  1  bus read strobe
- cfg_addr  out  CGRA_CFG_ADDR_WIDTH  bus address
- cfg_wr_data  out  CGRA_CFG_DATA_WIDTH  bus write data
- cfg_rd_data  in  NUM_COLUMNS x CGRA_CFG_DATA_WIDTH  per-column read data (0 when not valid)
- cfg_rd_data_valid  in  NUM_COLUMNS  per-column read valid

Behaviour:
- Reset: every output is 0 and the state is IDLE. An asserted reset mid-transaction drops the transaction; no response is produced.
- States:
  - IDLE: req_ready=1. On req_valid, latch wr/addr/data and go to WR if req_wr=1, else RD_ISSUE.
  - WR: cfg_wr_en=1 with cfg_addr/cfg_wr_data for exactly 1 cycle, then RESP.
  - RD_ISSUE: cfg_rd_en=1 with cfg_addr for exactly 1 cycle, cfg_wr_data=0. Clear the timeout counter. Go to RD_WAIT.
  - RD_WAIT: no strobes.
    - If any cfg_rd_data_valid bit is set: capture the OR of all cfg_rd_data lanes. Set err=1 if more than one valid bit is set. Go to RESP.
    - Otherwise increment the counter; when it reaches RD_TIMEOUT, set data=0, err=1 and go to RESP.
    - A valid arriving in the same cycle the counter would expire wins over the timeout.
  - RESP: resp_valid=1 with stable resp_data/resp_err. When resp_ready=1, go to IDLE and drop resp_valid the next cycle.
- Bus outputs: cfg_addr/cfg_wr_data are 0 whenever neither strobe is high. All bus outputs are registered.
- req_ready is 0 in every state except IDLE. There is no back-to-back acceptance while a response is pending.
- Latency with resp_ready tied high, handshake in cycle T:
  - write: cfg_wr_en at T+1, resp_valid at T+2.
  - read to a single-cycle responder: cfg_rd_en at T+1, valid returned at T+2, resp_valid at T+3.
- Column-id range is not checked. An address with id >= NUM_COLUMNS gets no read response and ends in timeout; a write to it completes normally.
- Writes never report an error.

Decomposition:
- Shared package cgra_cfg_pkg holds:
  - CGRA_CFG_ADDR_WIDTH and CGRA_CFG_DATA_WIDTH;
  - the field positions COL_ID_LSB=0, COL_ID_MSB=4, REG_IDX_LSB=8, REG_IDX_MSB=15;
  - the state enum cfg_init_state_e.
- One sub-module, cgra_cfg_rd_collector: a combinational OR-reduce of the data lanes, plus any_valid and multi_valid flags from cfg_rd_data_valid.

Test Plan:
- Write req_addr=0x0000_0503 (reg 5, column 3), data 0xDEADBEEF -> cfg_wr_en pulses 1 cycle at T+1 with that addr/data; resp_valid at T+2, err=0, data=0.
- Read the same address against a column model returning 0xDEADBEEF one cycle after cfg_rd_en -> cfg_rd_en 1 cycle at T+1; resp_valid at T+3, resp_data=0xDEADBEEF, err=0.
- Read addr column id 31 with NUM_COLUMNS=4 -> no valid; after RD_TIMEOUT=15 wait cycles resp_valid with data=0, err=1.
- Two column models both assert valid with 0x0F and 0xF0 -> resp_data=0xFF, err=1.
- Hold resp_ready=0 for 5 cycles -> resp_valid/data stable and req_ready=0 throughout; a new req_valid is not accepted until the cycle after resp_ready=1.
- Assert rst_n=0 in RD_WAIT -> all outputs 0 immediately; after release, req_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cgra_cfg_pkg
// Shared definitions for the CGRA column configuration bus initiator:
//   - default address/data widths of the config bus
//   - bit positions of the column id and register index inside an address
//   - state encoding of the initiator FSM
// No ports (package).
// -----------------------------------------------------------------------------
package cgra_cfg_pkg;

   localparam int CGRA_CFG_ADDR_WIDTH = 32;
   localparam int CGRA_CFG_DATA_WIDTH = 32;

   // Address field layout: addr[4:0] selects the column, addr[15:8] the register.
   localparam int COL_ID_LSB  = 0;
   localparam int COL_ID_MSB  = 4;
   localparam int REG_IDX_LSB = 8;
   localparam int REG_IDX_MSB = 15;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR       = 3'd1,
      RD_ISSUE = 3'd2,
      RD_WAIT  = 3'd3,
      RESP     = 3'd4
   } cfg_init_state_e;

endpackage : cgra_cfg_pkg

// File: rtl/cgra_cfg_initiator_rd_collector.sv
// -----------------------------------------------------------------------------
// cgra_cfg_initiator_rd_collector
// Combinational collector for the per-column read return lanes. Columns drive
// zero on their lane when not answering, so the returned word is simply the
// OR of every lane.
// Ports:
//   cfg_rd_data       in   NUM_COLUMNS x CGRA_CFG_DATA_WIDTH  per-column read data
//   cfg_rd_data_valid in   NUM_COLUMNS                        per-column read valid
//   rd_data_or        out  CGRA_CFG_DATA_WIDTH                OR of all lanes
//   any_valid         out  1                                  at least one column answered
//   multi_valid       out  1                                  more than one column answered
// -----------------------------------------------------------------------------
module cgra_cfg_initiator_rd_collector #(
   parameter int NUM_COLUMNS         = 32,
   parameter int CGRA_CFG_DATA_WIDTH = cgra_cfg_pkg::CGRA_CFG_DATA_WIDTH
) (
   input  logic [NUM_COLUMNS-1:0][CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
   input  logic [NUM_COLUMNS-1:0]                          cfg_rd_data_valid,
   output logic [CGRA_CFG_DATA_WIDTH-1:0]                  rd_data_or,
   output logic                                            any_valid,
   output logic                                            multi_valid
);

   import cgra_cfg_pkg::*;

   always_comb begin
      // NOTE: every always_comb output gets a default before any conditional
      // or loop update, otherwise synthesis infers a latch.
      rd_data_or = '0;
      for (int i = 0; i < NUM_COLUMNS; i++) begin
         rd_data_or = rd_data_or | cfg_rd_data[i];
      end
   end

   assign any_valid = |cfg_rd_data_valid;

   // Clearing the lowest set bit leaves something behind only if two or more
   // bits were set.
   assign multi_valid = |(cfg_rd_data_valid & (cfg_rd_data_valid - NUM_COLUMNS'(1)));

endmodule : cgra_cfg_initiator_rd_collector

// File: rtl/cgra_cfg_initiator.sv
// -----------------------------------------------------------------------------
// cgra_cfg_initiator
// Initiator of the CGRA column configuration register-file bus. Takes one
// read/write request at a time over valid/ready, drives the shared config bus
// to all columns, collects the read return and hands back exactly one response
// per request. Reads that nobody answers within RD_TIMEOUT wait cycles, or that
// several columns answer, return with resp_err set.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_wr, req_addr, req_wr_data     request: 1=write, address, write data
//   resp_valid/resp_ready             response handshake (valid held until ready)
//   resp_data, resp_err               read data (0 for writes/errors), error flag
//   cfg_wr_en, cfg_rd_en              bus write / read strobes (1 cycle each)
//   cfg_addr, cfg_wr_data             bus address / write data (0 when no strobe)
//   cfg_rd_data, cfg_rd_data_valid    per-column read returns
// -----------------------------------------------------------------------------
module cgra_cfg_initiator #(
   parameter int CGRA_CFG_ADDR_WIDTH = cgra_cfg_pkg::CGRA_CFG_ADDR_WIDTH,
   parameter int CGRA_CFG_DATA_WIDTH = cgra_cfg_pkg::CGRA_CFG_DATA_WIDTH,
   parameter int NUM_COLUMNS         = 32,
   parameter int RD_TIMEOUT          = 15
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            req_valid,
   output logic                                            req_ready,
   input  logic                                            req_wr,
   input  logic [CGRA_CFG_ADDR_WIDTH-1:0]                  req_addr,
   input  logic [CGRA_CFG_DATA_WIDTH-1:0]                  req_wr_data,
   output logic                                            resp_valid,
   input  logic                                            resp_ready,
   output logic [CGRA_CFG_DATA_WIDTH-1:0]                  resp_data,
   output logic                                            resp_err,
   output logic                                            cfg_wr_en,
   output logic                                            cfg_rd_en,
   output logic [CGRA_CFG_ADDR_WIDTH-1:0]                  cfg_addr,
   output logic [CGRA_CFG_DATA_WIDTH-1:0]                  cfg_wr_data,
   input  logic [NUM_COLUMNS-1:0][CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
   input  logic [NUM_COLUMNS-1:0]                          cfg_rd_data_valid
);

   import cgra_cfg_pkg::*;

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   // Value of the wait counter in the last RD_WAIT cycle before timing out.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   cfg_init_state_e                state;
   logic [CNT_W-1:0]               wait_cnt;
   logic [CGRA_CFG_DATA_WIDTH-1:0] rd_data_or;
   logic                           any_valid;
   logic                           multi_valid;

   cgra_cfg_initiator_rd_collector #(
      .NUM_COLUMNS         (NUM_COLUMNS),
      .CGRA_CFG_DATA_WIDTH (CGRA_CFG_DATA_WIDTH)
   ) u_rd_collector (
      .cfg_rd_data       (cfg_rd_data),
      .cfg_rd_data_valid (cfg_rd_data_valid),
      .rd_data_or        (rd_data_or),
      .any_valid         (any_valid),
      .multi_valid       (multi_valid)
   );

   // NOTE: sequential state uses non-blocking (<=) assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_err    <= 1'b0;
         cfg_wr_en   <= 1'b0;
         cfg_rd_en   <= 1'b0;
         cfg_addr    <= '0;
         cfg_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ready && req_valid) begin
                  // The request is captured straight into the bus registers;
                  // they are the only place the address/data are needed.
                  req_ready <= 1'b0;
                  cfg_addr  <= req_addr;
                  if (req_wr) begin
                     cfg_wr_en   <= 1'b1;
                     cfg_wr_data <= req_wr_data;
                     state       <= WR;
                  end else begin
                     cfg_rd_en <= 1'b1;
                     state     <= RD_ISSUE;
                  end
               end else begin
                  // Covers the first cycle after reset, where ready is still 0.
                  req_ready <= 1'b1;
               end
            end

            WR: begin
               cfg_wr_en   <= 1'b0;
               cfg_addr    <= '0;
               cfg_wr_data <= '0;
               resp_valid  <= 1'b1;
               resp_data   <= '0;
               resp_err    <= 1'b0;
               state       <= RESP;
            end

            RD_ISSUE: begin
               cfg_rd_en <= 1'b0;
               cfg_addr  <= '0;
               wait_cnt  <= '0;
               state     <= RD_WAIT;
            end

            RD_WAIT: begin
               // A return in the final wait cycle is checked first, so it wins
               // over the timeout.
               if (any_valid) begin
                  resp_valid <= 1'b1;
                  resp_data  <= rd_data_or;
                  resp_err   <= multi_valid;
                  state      <= RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  resp_valid <= 1'b1;
                  resp_data  <= '0;
                  resp_err   <= 1'b1;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_data  <= '0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : cgra_cfg_initiator

// File: tb/tb_cgra_cfg_initiator.sv
// -----------------------------------------------------------------------------
// tb_cgra_cfg_initiator
// Self-checking bench for cgra_cfg_initiator with 4 columns and RD_TIMEOUT=15.
// A column model answers reads after a programmable delay; a reference memory
// predicts read data from the stream of requests.
// -----------------------------------------------------------------------------
module tb_cgra_cfg_initiator;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int NCOL  = 4;
   localparam int TMO   = 15;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     req_valid = 1'b0;
   logic                     req_ready;
   logic                     req_wr = 1'b0;
   logic [AW-1:0]            req_addr = '0;
   logic [DW-1:0]            req_wr_data = '0;
   logic                     resp_valid;
   logic                     resp_ready = 1'b0;
   logic [DW-1:0]            resp_data;
   logic                     resp_err;
   logic                     cfg_wr_en;
   logic                     cfg_rd_en;
   logic [AW-1:0]            cfg_addr;
   logic [DW-1:0]            cfg_wr_data;
   logic [NCOL-1:0][DW-1:0]  col_data;
   logic [NCOL-1:0]          col_valid;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cgra_cfg_initiator #(
      .CGRA_CFG_ADDR_WIDTH (AW),
      .CGRA_CFG_DATA_WIDTH (DW),
      .NUM_COLUMNS         (NCOL),
      .RD_TIMEOUT          (TMO)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_wr            (req_wr),
      .req_addr          (req_addr),
      .req_wr_data       (req_wr_data),
      .resp_valid        (resp_valid),
      .resp_ready        (resp_ready),
      .resp_data         (resp_data),
      .resp_err          (resp_err),
      .cfg_wr_en         (cfg_wr_en),
      .cfg_rd_en         (cfg_rd_en),
      .cfg_addr          (cfg_addr),
      .cfg_wr_data       (cfg_wr_data),
      .cfg_rd_data       (col_data),
      .cfg_rd_data_valid (col_valid)
   );

   // ---------------- column model ----------------
   bit [DW-1:0] col_mem [NCOL][256];
   bit          pend = 1'b0;
   int          cd = 0;
   logic [AW-1:0] pend_addr = '0;
   int          rsp_delay = 1;   // cycles from cfg_rd_en to the valid return
   bit          dual_mode = 1'b0; // columns 0 and 1 both answer 0x0F / 0xF0

   always @(posedge clk) begin
      if (cfg_wr_en && cfg_addr[4:0] < NCOL)
         col_mem[cfg_addr[1:0]][cfg_addr[15:8]] <= cfg_wr_data;
      if (cfg_rd_en) begin
         pend      <= 1'b1;
         cd        <= rsp_delay - 1;
         pend_addr <= cfg_addr;
      end else if (pend) begin
         if (cd == 0) pend <= 1'b0;
         else         cd   <= cd - 1;
      end
   end

   always_comb begin
      col_valid = '0;
      col_data  = '0;
      if (pend && cd == 0) begin
         if (dual_mode) begin
            col_valid   = 4'b0011;
            col_data[0] = 32'h0000_000F;
            col_data[1] = 32'h0000_00F0;
         end else if (pend_addr[4:0] < NCOL) begin
            col_valid[pend_addr[1:0]] = 1'b1;
            col_data[pend_addr[1:0]]  = col_mem[pend_addr[1:0]][pend_addr[15:8]];
         end
      end
   end

   // ---------------- reference model ----------------
   bit [DW-1:0] mem_ref [NCOL][256];

   function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (a[4:0] < NCOL) mem_ref[a[1:0]][a[15:8]] = d;
   endfunction

   // Expected {data, err, response cycle offset from handshake} for a request.
   task automatic ref_expect(input bit wr, input logic [AW-1:0] a, input int delay,
                             output logic [DW-1:0] ed, output logic ee, output int el);
      if (wr) begin
         ed = '0; ee = 1'b0; el = 2;
      end else if (a[4:0] >= NCOL || delay > TMO) begin
         ed = '0; ee = 1'b1; el = TMO + 2;
      end else begin
         ed = mem_ref[a[1:0]][a[15:8]]; ee = 1'b0; el = 2 + delay;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int delay, input int stall,
                         output logic [DW-1:0] rdata, output logic rerr, output int lat);
      int n;
      rsp_delay = delay;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) check({tag, " req_ready_wait"}, 0, 1);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wr_data = data;
      @(posedge clk); #1;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wr_data = '0;
      check({tag, " strobe"}, {cfg_wr_en, cfg_rd_en}, {wr, !wr});
      check({tag, " cfg_addr"}, cfg_addr, addr);
      check({tag, " cfg_wr_data"}, cfg_wr_data, wr ? data : 32'h0);
      @(posedge clk); #1;
      check({tag, " bus_idle"}, {cfg_wr_en, cfg_rd_en, |cfg_addr, |cfg_wr_data}, 0);
      lat = 2; n = 0;
      while (!resp_valid && n < 40) begin @(posedge clk); #1; lat++; n++; end
      if (!resp_valid) check({tag, " resp_wait"}, 0, 1);
      rdata = resp_data; rerr = resp_err;
      for (int i = 0; i < stall; i++) begin
         check({tag, " stall_hold"}, {resp_valid, req_ready, resp_err, resp_data},
               {1'b1, 1'b0, rerr, rdata});
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, " resp_drop"}, {resp_valid, req_ready}, 2'b01);
      n = 0;
      while (pend && n < 40) begin @(posedge clk); #1; n++; end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          delay;
      bit          dual;
      logic [31:0] exp_data;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [DW-1:0] rd, ed;
      logic          re, ee;
      int            lat, el, n;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("reset ctrl", {req_ready, resp_valid, resp_err, cfg_wr_en, cfg_rd_en}, 0);
      check("reset resp_data", resp_data, 0);
      check("reset cfg_addr", cfg_addr, 0);
      check("reset cfg_wr_data", cfg_wr_data, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post-reset req_ready", req_ready, 1);

      // ---- table-driven vectors ----
      //          wr    addr           data          dly dual exp_data       err lat
      vecs[0] = '{1'b1, 32'h0000_0503, 32'hDEAD_BEEF, 1, 0, 32'h0,          0, 2};
      vecs[1] = '{1'b0, 32'h0000_0503, 32'h0,         1, 0, 32'hDEAD_BEEF,  0, 3};
      vecs[2] = '{1'b0, 32'h0000_001F, 32'h0,         1, 0, 32'h0,          1, 17};
      vecs[3] = '{1'b1, 32'h0000_7F02, 32'h1234_5678, 1, 0, 32'h0,          0, 2};
      vecs[4] = '{1'b0, 32'h0000_7F02, 32'h0,        15, 0, 32'h1234_5678,  0, 17};
      vecs[5] = '{1'b0, 32'h0000_7F02, 32'h0,        16, 0, 32'h0,          1, 17};
      vecs[6] = '{1'b1, 32'h0000_0106, 32'hCAFE_0006, 1, 0, 32'h0,          0, 2};
      vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         1, 1, 32'h0000_00FF,  1, 3};
      vecs[8] = '{1'b0, 32'h0000_0001, 32'h0,         2, 0, 32'h0,          0, 4};

      for (int i = 0; i < 9; i++) begin
         dual_mode = vecs[i].dual;
         do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                vecs[i].delay, 0, rd, re, lat);
         if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d resp_data", i), rd, vecs[i].exp_data);
         check($sformatf("vec%0d resp_err", i), re, vecs[i].exp_err);
         check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      end
      dual_mode = 1'b0;

      // ---- response back-pressure with a second request waiting ----
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr = 32'h0000_0201; req_wr_data = 32'hA5A5_0001;
      @(posedge clk); #1;
      req_addr = 32'h0000_0302; req_wr_data = 32'h5A5A_0002;
      n = 0;
      while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         check("bp hold", {resp_valid, req_ready, cfg_wr_en, resp_err, resp_data},
               {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("bp release", {resp_valid, req_ready, cfg_wr_en}, 3'b010);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp second accept", {cfg_wr_en, req_ready}, 2'b10);
      check("bp second addr", cfg_addr, 32'h0000_0302);
      check("bp second data", cfg_wr_data, 32'h5A5A_0002);
      ref_write(32'h0000_0201, 32'hA5A5_0001);
      ref_write(32'h0000_0302, 32'h5A5A_0002);
      n = 0;
      while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("bp second resp", {resp_valid, resp_err}, 2'b10);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // ---- randomized traffic against the reference model ----
      for (int t = 0; t < 40; t++) begin
         bit          wr;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         int          dly, stall;
         wr    = $urandom_range(0, 1) == 1;
         a     = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 3'h0, 5'($urandom_range(0, 5))};
         d     = $urandom;
         dly   = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 3);
         stall = $urandom_range(0, 3);
         ref_expect(wr, a, dly, ed, ee, el);
         do_txn($sformatf("rnd%0d", t), wr, a, d, dly, stall, rd, re, lat);
         if (wr) ref_write(a, d);
         check($sformatf("rnd%0d resp_data", t), rd, ed);
         check($sformatf("rnd%0d resp_err", t), re, ee);
         check($sformatf("rnd%0d latency", t), lat, el);
      end

      // ---- reset while waiting for a read that nobody answers ----
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0405;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = '0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst ctrl", {req_ready, resp_valid, resp_err, cfg_wr_en, cfg_rd_en}, 0);
      check("midrst resp_data", resp_data, 0);
      check("midrst cfg_addr", cfg_addr, 0);
      check("midrst cfg_wr_data", cfg_wr_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (resp_valid) n++;
         @(posedge clk); #1;
      end
      check("midrst no response", n, 0);
      check("midrst req_ready", req_ready, 1);
      do_txn("midrst write", 1'b1, 32'h0000_0A03, 32'h0BAD_F00D, 1, 1, rd, re, lat);
      check("midrst write data", rd, 0);
      check("midrst write err", re, 0);
      check("midrst write latency", lat, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_cgra_cfg_initiator
